// File: rtl/conv_sched_pkg.sv
// Shared definitions for the convolution tile scheduler: state encoding and
// index/counter width helpers.
package conv_sched_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] S_ISSUE = 3'd1;
   localparam logic [STATE_W-1:0] S_WAIT  = 3'd2;
   localparam logic [STATE_W-1:0] S_DRAIN = 3'd3;
   localparam logic [STATE_W-1:0] S_NEXT  = 3'd4;
   localparam logic [STATE_W-1:0] S_DONE  = 3'd5;

   // Width able to hold 0..n, with one spare bit so n=1 still yields a 1-bit index
   function automatic int unsigned idx_width(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/sched_drain_counter.sv
// Loadable down-counter used to time systolic-array flush windows; zero_o is
// registered and mirrors count==0.
module sched_drain_counter #(
   parameter int unsigned WIDTH      = 6,
   parameter int unsigned LOAD_VALUE = 31
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic en_i,
   output logic zero_o
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             zero_q;

   // Load has priority; decrement saturates at zero
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = WIDTH'(LOAD_VALUE);
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         zero_q  <= 1'b1;
      end else begin
         count_q <= count_d;
         zero_q  <= (count_d == '0);
      end
   end

   assign zero_o = zero_q;

endmodule

// File: rtl/conv_tile_scheduler.sv
// Sequencer for convolution GEMM tiles: walks the row/column tile grid, issues
// data-mover starts with incremental base addresses and psum accumulate flags.
module conv_tile_scheduler
   import conv_sched_pkg::*;
#(
   parameter int unsigned PE_SIZE         = 16,
   parameter int unsigned ROW_TILES       = 5,
   parameter int unsigned COL_TILES       = 18,
   parameter int unsigned WEIGHT_ROW_NUM  = 70,
   parameter int unsigned DRAIN_CYCLES    = 32,
   parameter int unsigned MEM0_ADDR_WIDTH = 12,
   parameter int unsigned MEM1_ADDR_WIDTH = 12
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start_i,
   input  logic                                 abort_i,
   input  logic                                 mover_done_i,
   output logic                                 mover_start_o,
   output logic [MEM0_ADDR_WIDTH-1:0]           mem0_base_o,
   output logic [MEM1_ADDR_WIDTH-1:0]           mem1_base_o,
   output logic                                 acc_first_o,
   output logic                                 acc_last_o,
   output logic [idx_width(ROW_TILES)-1:0]      row_idx_o,
   output logic [idx_width(COL_TILES)-1:0]      col_idx_o,
   output logic                                 busy_o,
   output logic                                 done_o,
   output logic                                 err_o
);

   localparam int unsigned ROW_W = idx_width(ROW_TILES);
   localparam int unsigned COL_W = idx_width(COL_TILES);
   localparam int unsigned DRN_W = idx_width(DRAIN_CYCLES);

   logic [STATE_W-1:0]         state_q, state_d;
   logic [ROW_W-1:0]           row_q, row_d;
   logic [COL_W-1:0]           col_q, col_d, col_inc;
   logic [MEM0_ADDR_WIDTH-1:0] mem0_q, mem0_d;
   logic [MEM1_ADDR_WIDTH-1:0] mem1_q, mem1_d;
   logic                       first_q, first_d, last_q, last_d;
   logic                       start_q, start_d, busy_q, busy_d;
   logic                       done_q, done_d, err_q, err_d;
   logic                       drain_load, drain_zero;

   sched_drain_counter #(
      .WIDTH      (DRN_W),
      .LOAD_VALUE (DRAIN_CYCLES - 1)
   ) u_drain (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (drain_load),
      .en_i   (state_q == S_DRAIN),
      .zero_o (drain_zero)
   );

   assign col_inc = col_q + COL_W'(1);

   // Next-state, index/address update and registered-output decode
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      mem0_d     = mem0_q;
      mem1_d     = mem1_q;
      first_d    = first_q;
      last_d     = last_q;
      err_d      = err_q;
      drain_load = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i && !abort_i) begin
               state_d = S_ISSUE;
               row_d   = '0;
               col_d   = '0;
               mem0_d  = '0;
               mem1_d  = '0;
               first_d = 1'b1;
               last_d  = (COL_TILES == 1);
               err_d   = 1'b0;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (mover_done_i) begin
               state_d    = S_DRAIN;
               drain_load = 1'b1;
            end
         end
         S_DRAIN: begin
            if (drain_zero) state_d = S_NEXT;
         end
         S_NEXT: begin
            if (col_q == COL_W'(COL_TILES - 1)) begin
               col_d = '0;
               if (row_q == ROW_W'(ROW_TILES - 1)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ISSUE;
                  row_d   = row_q + ROW_W'(1);
                  mem0_d  = mem0_q + MEM0_ADDR_WIDTH'(PE_SIZE);
                  mem1_d  = '0;
                  first_d = 1'b1;
                  last_d  = (COL_TILES == 1);
               end
            end else begin
               state_d = S_ISSUE;
               col_d   = col_inc;
               mem0_d  = mem0_q + MEM0_ADDR_WIDTH'(PE_SIZE);
               mem1_d  = mem1_q + MEM1_ADDR_WIDTH'(WEIGHT_ROW_NUM);
               first_d = 1'b0;
               last_d  = (col_inc == COL_W'(COL_TILES - 1));
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // A mover completion is only legal while waiting for it
      if (mover_done_i && (state_q != S_WAIT)) err_d = 1'b1;

      if (abort_i) begin
         state_d = S_IDLE;
         row_d   = '0;
         col_d   = '0;
         mem0_d  = '0;
         mem1_d  = '0;
         first_d = 1'b0;
         last_d  = 1'b0;
      end

      start_d = (state_d == S_ISSUE);
      done_d  = (state_d == S_DONE);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         mem0_q  <= '0;
         mem1_q  <= '0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         mem0_q  <= mem0_d;
         mem1_q  <= mem1_d;
         first_q <= first_d;
         last_q  <= last_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign mover_start_o = start_q;
   assign mem0_base_o   = mem0_q;
   assign mem1_base_o   = mem1_q;
   assign acc_first_o   = first_q;
   assign acc_last_o    = last_q;
   assign row_idx_o     = row_q;
   assign col_idx_o     = col_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Scoreboard bench for conv_tile_scheduler: a 2x3 grid instance plus a 1x1 instance.
module tb_conv_tile_scheduler;

   localparam int unsigned RT   = 2;
   localparam int unsigned CT   = 3;
   localparam int unsigned PE   = 4;
   localparam int unsigned WRN  = 8;
   localparam int unsigned DC   = 4;
   localparam int unsigned DC_B = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        a_start_i, a_abort_i, a_done_i;
   logic        a_mstart, a_first, a_last, a_busy, a_done, a_err;
   logic [11:0] a_mem0, a_mem1;
   logic [1:0]  a_row;
   logic [2:0]  a_col;

   logic        b_start_i, b_abort_i, b_done_i;
   logic        b_mstart, b_first, b_last, b_busy, b_done, b_err;
   logic [11:0] b_mem0, b_mem1;
   logic [0:0]  b_row, b_col;

   conv_tile_scheduler #(
      .PE_SIZE(PE), .ROW_TILES(RT), .COL_TILES(CT), .WEIGHT_ROW_NUM(WRN),
      .DRAIN_CYCLES(DC), .MEM0_ADDR_WIDTH(12), .MEM1_ADDR_WIDTH(12)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .start_i(a_start_i), .abort_i(a_abort_i),
      .mover_done_i(a_done_i), .mover_start_o(a_mstart), .mem0_base_o(a_mem0),
      .mem1_base_o(a_mem1), .acc_first_o(a_first), .acc_last_o(a_last),
      .row_idx_o(a_row), .col_idx_o(a_col), .busy_o(a_busy), .done_o(a_done),
      .err_o(a_err)
   );

   conv_tile_scheduler #(
      .PE_SIZE(PE), .ROW_TILES(1), .COL_TILES(1), .WEIGHT_ROW_NUM(WRN),
      .DRAIN_CYCLES(DC_B), .MEM0_ADDR_WIDTH(12), .MEM1_ADDR_WIDTH(12)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .start_i(b_start_i), .abort_i(b_abort_i),
      .mover_done_i(b_done_i), .mover_start_o(b_mstart), .mem0_base_o(b_mem0),
      .mem1_base_o(b_mem1), .acc_first_o(b_first), .acc_last_o(b_last),
      .row_idx_o(b_row), .col_idx_o(b_col), .busy_o(b_busy), .done_o(b_done),
      .err_o(b_err)
   );

   typedef struct packed {
      logic [11:0] mem0;
      logic [11:0] mem1;
      logic        first;
      logic        last;
      logic [1:0]  row;
      logic [2:0]  col;
   } tile_t;

   tile_t sb[$];
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int a_starts = 0, a_dones = 0, b_starts = 0, b_dones = 0;
   int st_cyc = 0, last_done = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Pop the expected tile on every mover start of the 2x3 instance
   always @(negedge clk) begin : mon_a
      tile_t t;
      if (rst_n && a_mstart) begin
         a_starts++;
         check("sb_nonempty", 32'(sb.size() > 0), 32'(1));
         if (sb.size() > 0) begin
            t = sb.pop_front();
            check("mem0_base", 32'(a_mem0), 32'(t.mem0));
            check("mem1_base", 32'(a_mem1), 32'(t.mem1));
            check("acc_first", 32'(a_first), 32'(t.first));
            check("acc_last",  32'(a_last),  32'(t.last));
            check("row_idx",   32'(a_row),   32'(t.row));
            check("col_idx",   32'(a_col),   32'(t.col));
         end
      end
      if (rst_n && a_done) begin
         a_dones++;
         check("busy_at_done", 32'(a_busy), 32'(1));
      end
      if (rst_n && b_mstart) b_starts++;
      if (rst_n && b_done)   b_dones++;
   end

   task automatic push_job();
      tile_t t;
      for (int r = 0; r < RT; r++) begin
         for (int c = 0; c < CT; c++) begin
            t.mem0  = 12'((r * CT + c) * PE);
            t.mem1  = 12'(c * WRN);
            t.first = (c == 0);
            t.last  = (c == CT - 1);
            t.row   = 2'(r);
            t.col   = 3'(c);
            sb.push_back(t);
         end
      end
   endtask

   task automatic pulse_start();
      a_start_i = 1'b1;
      st_cyc = cyc;
      @(negedge clk);
      a_start_i = 1'b0;
   endtask

   task automatic wait_start(input int ref_cyc, input int lat, input string tag);
      int n = 0;
      while (!a_mstart && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(cyc - ref_cyc), 32'(lat));
   endtask

   // Act as the data mover: answer a start 5 cycles later, optionally re-pulse in DRAIN
   task automatic serve_tile(input int ref_cyc, input int lat, input bit extra_done);
      wait_start(ref_cyc, lat, "start_spacing");
      repeat (5) @(negedge clk);
      a_done_i  = 1'b1;
      last_done = cyc;
      @(negedge clk);
      a_done_i = 1'b0;
      if (extra_done) begin
         a_done_i = 1'b1;
         @(negedge clk);
         a_done_i = 1'b0;
      end
   endtask

   task automatic run_job(input bit restart_mid, input bit extra_done, input bit exp_err);
      int s0, d0, n;
      s0 = a_starts;
      d0 = a_dones;
      push_job();
      pulse_start();
      check("err_clear_on_start", 32'(a_err), 32'(0));
      serve_tile(st_cyc, 1, extra_done);
      for (int i = 1; i < RT * CT; i++) begin
         if (restart_mid && i == 2) begin
            a_start_i = 1'b1;
            @(negedge clk);
            a_start_i = 1'b0;
         end
         serve_tile(last_done, DC + 2, 1'b0);
      end
      n = 0;
      while (!a_done && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("done_latency", 32'(cyc - last_done), 32'(DC + 2));
      @(negedge clk);
      check("busy_after_done", 32'(a_busy), 32'(0));
      check("done_count", 32'(a_dones - d0), 32'(1));
      check("tile_count", 32'(a_starts - s0), 32'(RT * CT));
      check("sb_drained", 32'(sb.size()), 32'(0));
      check("err_after_job", 32'(a_err), 32'(exp_err));
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int s0, d0, n;
      rst_n = 1'b0;
      a_start_i = 1'b0; a_abort_i = 1'b0; a_done_i = 1'b0;
      b_start_i = 1'b0; b_abort_i = 1'b0; b_done_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy",   32'(a_busy),   32'(0));
      check("rst_mstart", 32'(a_mstart), 32'(0));
      check("rst_done",   32'(a_done),   32'(0));
      check("rst_err",    32'(a_err),    32'(0));
      check("rst_mem0",   32'(a_mem0),   32'(0));
      check("rst_first",  32'(a_first),  32'(0));
      check("rst_b_busy", 32'(b_busy),   32'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Nominal job, with a start re-pulsed while busy
      run_job(1'b1, 1'b0, 1'b0);

      // Completion seen in IDLE sets err; job with a stray completion in DRAIN
      a_done_i = 1'b1;
      @(negedge clk);
      a_done_i = 1'b0;
      check("err_idle_done", 32'(a_err), 32'(1));
      check("busy_idle_done", 32'(a_busy), 32'(0));
      run_job(1'b0, 1'b1, 1'b1);

      // Abort during the DRAIN of tile 2
      s0 = a_starts;
      push_job();
      pulse_start();
      check("err_clear_on_start", 32'(a_err), 32'(0));
      serve_tile(st_cyc, 1, 1'b0);
      serve_tile(last_done, DC + 2, 1'b0);
      serve_tile(last_done, DC + 2, 1'b0);
      a_abort_i = 1'b1;
      @(negedge clk);
      a_abort_i = 1'b0;
      check("abort_busy", 32'(a_busy), 32'(0));
      check("abort_row",  32'(a_row),  32'(0));
      check("abort_col",  32'(a_col),  32'(0));
      check("abort_mem0", 32'(a_mem0), 32'(0));
      check("abort_mem1", 32'(a_mem1), 32'(0));
      d0 = a_dones;
      repeat (12) @(negedge clk);
      check("abort_no_done", 32'(a_dones - d0), 32'(0));
      check("abort_tiles", 32'(a_starts - s0), 32'(3));
      sb.delete();
      run_job(1'b0, 1'b0, 1'b0);

      // Single-tile grid
      b_start_i = 1'b1;
      n = cyc;
      @(negedge clk);
      b_start_i = 1'b0;
      check("b_start_lat", 32'(b_mstart), 32'(1));
      check("b_first", 32'(b_first), 32'(1));
      check("b_last",  32'(b_last),  32'(1));
      check("b_mem0",  32'(b_mem0),  32'(0));
      check("b_mem1",  32'(b_mem1),  32'(0));
      check("b_busy",  32'(b_busy),  32'(1));
      repeat (5) @(negedge clk);
      b_done_i = 1'b1;
      n = cyc;
      @(negedge clk);
      b_done_i = 1'b0;
      d0 = 0;
      while (!b_done && d0 < 100) begin
         @(negedge clk);
         d0++;
      end
      check("b_done_latency", 32'(cyc - n), 32'(DC_B + 2));
      repeat (3) @(negedge clk);
      check("b_tile_count", 32'(b_starts), 32'(1));
      check("b_done_count", 32'(b_dones), 32'(1));
      check("b_err", 32'(b_err), 32'(0));

      // Asynchronous reset in the middle of WAIT
      push_job();
      pulse_start();
      repeat (2) @(negedge clk);
      check("busy_before_rst", 32'(a_busy), 32'(1));
      check("first_before_rst", 32'(a_first), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy",  32'(a_busy),  32'(0));
      check("arst_first", 32'(a_first), 32'(0));
      check("arst_mstart", 32'(a_mstart), 32'(0));
      @(negedge clk);
      sb.delete();
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_busy", 32'(a_busy), 32'(0));
      check("post_rst_row",  32'(a_row),  32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
